// File: rtl/gcd_pkg.sv
// Shared types and the fixed regression table for the GCD self-test driver.
package gcd_pkg;

   localparam int GCD_W       = 8;
   localparam int GCD_NUM_VEC = 24;

   typedef struct packed {
      logic [GCD_W-1:0] x;
      logic [GCD_W-1:0] y;
      logic             rst;
      logic [GCD_W-1:0] exp;
   } gcd_vec_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_NEXT,
      ST_DONE
   } gcd_state_t;

   // Entries with rst=1 expect 0: the unit is held in reset, operands ignored.
   function automatic gcd_vec_t gcd_vec_lookup(input logic [4:0] idx);
      case (idx)
         5'd0:    return '{8'd1,   8'd1,   1'b0, 8'd1};
         5'd1:    return '{8'd7,   8'd5,   1'b0, 8'd1};
         5'd2:    return '{8'd3,   8'd9,   1'b0, 8'd3};
         5'd3:    return '{8'd9,   8'd3,   1'b0, 8'd3};
         5'd4:    return '{8'd17,  8'd13,  1'b0, 8'd1};
         5'd5:    return '{8'd21,  8'd6,   1'b0, 8'd3};
         5'd6:    return '{8'd6,   8'd21,  1'b0, 8'd3};
         5'd7:    return '{8'd12,  8'd6,   1'b1, 8'd0};
         5'd8:    return '{8'd100, 8'd1,   1'b0, 8'd1};
         5'd9:    return '{8'd255, 8'd254, 1'b0, 8'd1};
         5'd10:   return '{8'd50,  8'd25,  1'b1, 8'd0};
         5'd11:   return '{8'd28,  8'd28,  1'b0, 8'd28};
         5'd12:   return '{8'd200, 8'd100, 1'b1, 8'd0};
         5'd13:   return '{8'd3,   8'd0,   1'b0, 8'd3};
         5'd14:   return '{8'd0,   8'd3,   1'b0, 8'd3};
         5'd15:   return '{8'd64,  8'd208, 1'b0, 8'd16};
         5'd16:   return '{8'd2,   8'd4,   1'b0, 8'd2};
         5'd17:   return '{8'd10,  8'd4,   1'b0, 8'd2};
         5'd18:   return '{8'd254, 8'd2,   1'b0, 8'd2};
         5'd19:   return '{8'd6,   8'd8,   1'b0, 8'd2};
         5'd20:   return '{8'd255, 8'd255, 1'b1, 8'd0};
         5'd21:   return '{8'd8,   8'd4,   1'b1, 8'd0};
         5'd22:   return '{8'd0,   8'd0,   1'b0, 8'd0};
         5'd23:   return '{8'd1,   8'd0,   1'b1, 8'd0};
         default: return '{8'd0,   8'd0,   1'b1, 8'd0};
      endcase
   endfunction

endpackage

// File: rtl/gcd_vector_driver_rom.sv
// Combinational index -> {x, y, rst, exp} lookup into the regression table.
module gcd_vector_rom
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_W
) (
   input  logic [4:0]       idx,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             rst,
   output logic [WIDTH-1:0] exp
);

   gcd_vec_t rec;

   assign rec = gcd_vec_lookup(idx);
   assign x   = WIDTH'(rec.x);
   assign y   = WIDTH'(rec.y);
   assign rst = rec.rst;
   assign exp = WIDTH'(rec.exp);

endmodule

// File: rtl/gcd_vector_driver.sv
// Replays the regression table into a GCD unit, samples gcd_output SETTLE cycles after
// each drive and counts mismatches; one vector costs SETTLE+3 cycles, start ignored while busy.
module gcd_vector_driver
   import gcd_pkg::*;
#(
   parameter int WIDTH   = GCD_W,
   parameter int NUM_VEC = GCD_NUM_VEC,
   parameter int LOOPS   = 50,
   parameter int SETTLE  = 4,
   parameter int ERR_W   = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] gcd_x,
   output logic [WIDTH-1:0] gcd_y,
   output logic             gcd_rst,
   input  logic [WIDTH-1:0] gcd_output,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [4:0]       mis_idx,
   output logic [WIDTH-1:0] mis_value,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int LW = (LOOPS  > 1) ? $clog2(LOOPS)  : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   gcd_state_t       state;
   logic [4:0]       vec_idx;
   logic [LW-1:0]    loop_cnt;
   logic [SW-1:0]    settle_cnt;
   logic [WIDTH-1:0] rom_x, rom_y, rom_exp;
   logic             rom_rst;

   gcd_vector_rom #(.WIDTH(WIDTH)) u_rom (
      .idx (vec_idx),
      .x   (rom_x),
      .y   (rom_y),
      .rst (rom_rst),
      .exp (rom_exp)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= ST_IDLE;
         vec_idx    <= '0;
         loop_cnt   <= '0;
         settle_cnt <= '0;
         gcd_x      <= '0;
         gcd_y      <= '0;
         gcd_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         mismatch   <= 1'b0;
         mis_idx    <= '0;
         mis_value  <= '0;
         err_cnt    <= '0;
      end else begin
         mismatch <= 1'b0;
         // Abort wins over start; error history survives until the next start.
         if (abort && state != ST_IDLE) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            gcd_rst <= 1'b1;
            gcd_x   <= '0;
            gcd_y   <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     vec_idx  <= '0;
                     loop_cnt <= '0;
                     err_cnt  <= '0;
                     done     <= 1'b0;
                     busy     <= 1'b1;
                     state    <= ST_APPLY;
                  end
               end
               ST_APPLY: begin
                  gcd_x      <= rom_x;
                  gcd_y      <= rom_y;
                  gcd_rst    <= rom_rst;
                  settle_cnt <= SW'(SETTLE - 1);
                  state      <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (settle_cnt == '0) state <= ST_CHECK;
                  else                  settle_cnt <= settle_cnt - 1'b1;
               end
               ST_CHECK: begin
                  if (gcd_output !== rom_exp) begin
                     mismatch  <= 1'b1;
                     mis_idx   <= vec_idx;
                     mis_value <= gcd_output;
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                  end
                  state <= ST_NEXT;
               end
               ST_NEXT: begin
                  if (vec_idx == 5'(NUM_VEC - 1)) begin
                     vec_idx <= '0;
                     if (loop_cnt == LW'(LOOPS - 1)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        gcd_rst <= 1'b1;
                        gcd_x   <= '0;
                        gcd_y   <= '0;
                        state   <= ST_DONE;
                     end else begin
                        loop_cnt <= loop_cnt + 1'b1;
                        state    <= ST_APPLY;
                     end
                  end else begin
                     vec_idx <= vec_idx + 1'b1;
                     state   <= ST_APPLY;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gcd_vector_driver.sv
// Two drivers (LOOPS=1/ERR_W=16 and LOOPS=2/ERR_W=4) against a behavioural GCD stub with
// selectable faults; expected mismatch events are queued at start and popped on each pulse.
module tb_gcd_vector_driver;

   typedef struct {
      int         idx;
      logic [7:0] val;
   } mis_t;

   localparam logic [7:0] TX [24] = '{1,7,3,9,17,21,6,12,100,255,50,28,200,3,0,64,2,10,254,6,255,8,0,1};
   localparam logic [7:0] TY [24] = '{1,5,9,3,13,6,21,6,1,254,25,28,100,0,3,208,4,4,2,8,255,4,0,0};
   localparam bit         TR [24] = '{0,0,0,0,0,0,0,1,0,0,1,0,1,0,0,0,0,0,0,0,1,1,0,1};
   localparam logic [7:0] TE [24] = '{1,1,3,3,1,3,3,0,1,1,0,28,0,3,3,16,2,2,2,2,0,0,0,0};

   logic clk, reset;
   logic s1, a1, s2, a2;
   logic [7:0] x1, y1, go1, mv1, x2, y2, go2, mv2;
   logic r1, busy1, done1, mm1, r2, busy2, done2, mm2;
   logic [4:0] mi1, mi2;
   logic [15:0] ec1;
   logic [3:0]  ec2;

   int mode1, mode2;
   logic [23:0] cf1, cf2;
   logic [23:0][7:0] cv1, cv2;
   mis_t q1[$], q2[$];
   int exp1, exp2;
   int n_cmp = 0, n_fail = 0;

   gcd_vector_driver #(.WIDTH(8), .NUM_VEC(24), .LOOPS(1), .SETTLE(4), .ERR_W(16)) u_dut1 (
      .Clock(clk), .Reset(reset), .start(s1), .abort(a1), .gcd_x(x1), .gcd_y(y1), .gcd_rst(r1),
      .gcd_output(go1), .busy(busy1), .done(done1), .mismatch(mm1), .mis_idx(mi1),
      .mis_value(mv1), .err_cnt(ec1));

   gcd_vector_driver #(.WIDTH(8), .NUM_VEC(24), .LOOPS(2), .SETTLE(4), .ERR_W(4)) u_dut2 (
      .Clock(clk), .Reset(reset), .start(s2), .abort(a2), .gcd_x(x2), .gcd_y(y2), .gcd_rst(r2),
      .gcd_output(go2), .busy(busy2), .done(done2), .mismatch(mm2), .mis_idx(mi2),
      .mis_value(mv2), .err_cnt(ec2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b, input logic r);
      logic [7:0] t;
      if (r) return 8'd0;
      while (b != 0) begin
         t = b;
         b = a % b;
         a = t;
      end
      return a;
   endfunction

   function automatic int find_idx(input logic [7:0] x, input logic [7:0] y, input logic r);
      for (int i = 0; i < 24; i++)
         if (TX[i] == x && TY[i] == y && TR[i] == r) return i;
      return -1;
   endfunction

   // mode 0: correct unit, 1: stuck 01, 2: stuck FF, 3: correct except flagged vectors
   function automatic logic [7:0] stub(input int mode, input logic [7:0] x, input logic [7:0] y,
                                       input logic r, input logic [23:0] cf, input logic [23:0][7:0] cv);
      int k;
      k = find_idx(x, y, r);
      case (mode)
         1: return 8'h01;
         2: return 8'hFF;
         3: if (k >= 0 && cf[k]) return cv[k];
         default: ;
      endcase
      return ref_gcd(x, y, r);
   endfunction

   assign go1 = stub(mode1, x1, y1, r1, cf1, cv1);
   assign go2 = stub(mode2, x2, y2, r2, cf2, cv2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic plan(input int dut, input int loops, input int nvec, output int cnt);
      mis_t e;
      logic [7:0] r;
      cnt = 0;
      for (int l = 0; l < loops; l++)
         for (int v = 0; v < nvec; v++) begin
            if (dut == 1) r = stub(mode1, TX[v], TY[v], TR[v], cf1, cv1);
            else          r = stub(mode2, TX[v], TY[v], TR[v], cf2, cv2);
            if (r !== TE[v]) begin
               e.idx = v;
               e.val = r;
               if (dut == 1) q1.push_back(e); else q2.push_back(e);
               cnt++;
            end
         end
   endtask

   task automatic pulse_start(input int dut);
      @(negedge clk);
      if (dut == 1) s1 = 1'b1; else s2 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      s2 = 1'b0;
   endtask

   // Counts edges until done; poke>0 re-pulses start after that edge to prove it is ignored.
   task automatic wait_done(input int dut, input int bound, input int poke, output int n);
      logic d;
      n = 0;
      d = 1'b0;
      while (n < bound && !d) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (dut == 2) s2 = (n == poke);
         d = (dut == 1) ? done1 : done2;
      end
      s2 = 1'b0;
      if (!d) begin
         n_cmp++;
         n_fail++;
         $display("FAIL dut%0d_done_timeout: no done within %0d cycles", dut, bound);
      end
   endtask

   always @(negedge clk) begin
      if (mm1 === 1'b1) begin
         mis_t e;
         n_cmp++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL mon1_unexpected: idx %0d value %0h, none expected", mi1, mv1);
         end else begin
            e = q1.pop_front();
            if (exp1 < 65535) exp1++;
            if (mi1 !== 5'(e.idx) || mv1 !== e.val || ec1 !== 16'(exp1)) begin
               n_fail++;
               $display("FAIL mon1_event: got idx %0d val %0h cnt %0d, expected idx %0d val %0h cnt %0d",
                        mi1, mv1, ec1, e.idx, e.val, exp1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mm2 === 1'b1) begin
         mis_t e;
         n_cmp++;
         if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL mon2_unexpected: idx %0d value %0h, none expected", mi2, mv2);
         end else begin
            e = q2.pop_front();
            if (exp2 < 15) exp2++;
            if (mi2 !== 5'(e.idx) || mv2 !== e.val || ec2 !== 4'(exp2)) begin
               n_fail++;
               $display("FAIL mon2_event: got idx %0d val %0h cnt %0d, expected idx %0d val %0h cnt %0d",
                        mi2, mv2, ec2, e.idx, e.val, exp2);
            end
         end
      end
   end

   initial begin
      int n, cnt;
      reset = 1'b1;
      s1 = 1'b0; a1 = 1'b0; s2 = 1'b0; a2 = 1'b0;
      mode1 = 0; mode2 = 0; cf1 = '0; cf2 = '0; cv1 = '0; cv2 = '0;
      exp1 = 0; exp2 = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_gcd_rst", r1, 1);      chk("rst_gcd_x", x1, 0);       chk("rst_gcd_y", y1, 0);
      chk("rst_busy", busy1, 0);      chk("rst_done", done1, 0);     chk("rst_mismatch", mm1, 0);
      chk("rst_err_cnt", ec1, 0);     chk("rst_mis_idx", mi1, 0);    chk("rst_mis_value", mv1, 0);
      chk("rst2_gcd_rst", r2, 1);     chk("rst2_busy", busy2, 0);    chk("rst2_err_cnt", ec2, 0);
      reset = 1'b0;

      // correct unit, single pass
      mode1 = 0; exp1 = 0;
      plan(1, 1, 24, cnt);
      pulse_start(1);
      chk("run_busy", busy1, 1);
      wait_done(1, 400, -1, n);
      chk("good_latency", n, 168);
      chk("good_err_cnt", ec1, 0);
      chk("done_busy", busy1, 0);
      chk("done_gcd_rst", r1, 1);
      chk("good_queue_left", q1.size(), 0);

      // stuck at 01
      mode1 = 1; exp1 = 0;
      plan(1, 1, 24, cnt);
      pulse_start(1);
      wait_done(1, 400, -1, n);
      chk("stuck01_latency", n, 168);
      chk("stuck01_err_cnt", ec1, 19);
      chk("stuck01_mis_idx", mi1, 23);
      chk("stuck01_mis_value", mv1, 8'h01);
      chk("stuck01_queue_left", q1.size(), 0);

      // random faults on random vectors
      for (int run = 0; run < 4; run++) begin
         mode1 = 3; exp1 = 0;
         cf1 = 24'($urandom);
         for (int v = 0; v < 24; v++) cv1[v] = 8'($urandom_range(0, 255));
         plan(1, 1, 24, cnt);
         pulse_start(1);
         wait_done(1, 400, -1, n);
         chk("rand_latency", n, 168);
         chk("rand_err_cnt", ec1, cnt);
         chk("rand_queue_left", q1.size(), 0);
      end

      // abort while vector 5 is in flight; only idx 2 and 3 were checked by then
      mode1 = 1; exp1 = 0;
      plan(1, 1, 5, cnt);
      pulse_start(1);
      repeat (37) @(negedge clk);
      a1 = 1'b1;
      @(negedge clk);
      a1 = 1'b0;
      chk("abort_busy", busy1, 0);    chk("abort_done", done1, 0);   chk("abort_gcd_rst", r1, 1);
      chk("abort_gcd_x", x1, 0);      chk("abort_err_cnt", ec1, cnt);
      chk("abort_mis_idx", mi1, 3);   chk("abort_mis_value", mv1, 8'h01);
      repeat (10) @(negedge clk);
      chk("abort_queue_left", q1.size(), 0);
      chk("abort_idle_busy", busy1, 0);
      mode1 = 0; exp1 = 0;
      plan(1, 1, 24, cnt);
      pulse_start(1);
      chk("restart_err_cnt", ec1, 0);
      @(negedge clk);
      chk("restart_x", x1, 1);        chk("restart_y", y1, 1);       chk("restart_rst", r1, 0);
      wait_done(1, 400, -1, n);
      chk("restart_latency", n, 167);
      chk("restart_queue_left", q1.size(), 0);

      // two passes, start re-pulsed mid-run
      mode2 = 0; exp2 = 0;
      plan(2, 2, 24, cnt);
      pulse_start(2);
      wait_done(2, 800, 100, n);
      chk("loop2_latency", n, 336);
      chk("loop2_err_cnt", ec2, 0);
      chk("loop2_queue_left", q2.size(), 0);

      // stuck FF, every vector fails, 4-bit counter saturates
      mode2 = 2; exp2 = 0;
      plan(2, 2, 24, cnt);
      pulse_start(2);
      wait_done(2, 800, -1, n);
      chk("sat_latency", n, 336);
      chk("sat_err_cnt", ec2, 15);
      chk("sat_mis_idx", mi2, 23);
      chk("sat_mis_value", mv2, 8'hFF);
      chk("sat_queue_left", q2.size(), 0);

      // abort and start together in DONE: abort wins
      @(negedge clk);
      a2 = 1'b1; s2 = 1'b1;
      @(negedge clk);
      a2 = 1'b0; s2 = 1'b0;
      chk("abort_start_busy", busy2, 0);
      chk("abort_start_done", done2, 0);
      chk("abort_start_err_kept", ec2, 15);
      repeat (3) @(negedge clk);
      chk("abort_start_idle_rst", r2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
